display_share_scheduler: RTL and testbench

Round-robin scheduler that shares the 8-digit seven-segment display driver between N_REQ requesters, each presenting a 32-bit hex value.
- Grants the display to one requester at a time for a fixed dwell time, then rotates to the next pending requester.
- Drives the driver's HEX_in and digit enables.
- Sits between application sources (counters, ALU results, switches) and the existing hex-to-7-seg multiplexer.

---
 rtl/display_share_scheduler.sv | 148 ++++++++++++++
 tb/tb_display_share_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_share_scheduler.sv
// Round-robin owner scheduler for the shared 8-digit seven-segment display driver.
// Optional OWNER_TAG_EN: leftmost hex digit shows the owner index instead of value[31:28].
module display_share_scheduler #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [32*N_REQ-1:0]      value,
    input  logic                     hold,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [31:0]              HEX_out,
    output logic [7:0]               digit_en,
    output logic                     active
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [OW-1:0]   owner_r, owner_s;
    logic [OW-1:0]   ptr_r, ptr_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [OW:0]     pick_s;
    logic [N_REQ-1:0] grant_r, grant_s;
    logic [31:0]     hex_r, hex_s, raw_s;
    logic [7:0]      digit_en_r;
    logic            active_r;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        return (idx == OW'(N_REQ - 1)) ? {OW{1'b0}} : idx + OW'(1);
    endfunction

    // Returns {found, index}; scanned from the far end so the nearest offset from start wins.
    function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] start);
        logic [OW:0] res;
        int          sum;
        int          idx;
        res = {(OW + 1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = int'(start) + k;
            idx = (sum >= N_REQ) ? sum - N_REQ : sum;
            res = r[idx] ? {1'b1, OW'(idx)} : res;
        end
        return res;
    endfunction

    // Arbitration, dwell counting and next-owner selection.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        pick_s  = {(OW + 1){1'b0}};
        case (state_r)
            IDLE: begin
                pick_s = rr_pick(req, ptr_r);
                cnt_s  = {CW{1'b0}};
                if (pick_s[OW]) begin
                    state_s = SHOW;
                    owner_s = pick_s[OW-1:0];
                    ptr_s   = wrap_inc(pick_s[OW-1:0]);
                end else begin
                    owner_s = {OW{1'b0}};
                end
            end
            SHOW: begin
                // Owner is the last candidate, so on plain expiry it is always found.
                pick_s = rr_pick(req, wrap_inc(owner_r));
                if (!req[owner_r] || (cnt_r == CNT_LAST && !hold)) begin
                    cnt_s = {CW{1'b0}};
                    if (pick_s[OW]) begin
                        owner_s = pick_s[OW-1:0];
                        ptr_s   = wrap_inc(pick_s[OW-1:0]);
                    end else begin
                        state_s = IDLE;
                        owner_s = {OW{1'b0}};
                    end
                end else if (!hold) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                owner_s = {OW{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Display data and one-hot grant for the next owner.
    always_comb begin
        raw_s   = value[{owner_s, 5'b00000} +: 32];
        grant_s = {N_REQ{1'b0}};
        hex_s   = 32'h0000_0000;
        if (state_s == SHOW) begin
            grant_s = {{(N_REQ - 1){1'b0}}, 1'b1} << owner_s;
`ifdef OWNER_TAG_EN
            hex_s   = {{(4 - OW){1'b0}}, owner_s, raw_s[27:0]};
`else
            hex_s   = raw_s;
`endif
        end else begin
            grant_s = {N_REQ{1'b0}};
            hex_s   = 32'h0000_0000;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            owner_r    <= {OW{1'b0}};
            ptr_r      <= {OW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            grant_r    <= {N_REQ{1'b0}};
            hex_r      <= 32'h0000_0000;
            digit_en_r <= 8'h00;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
            cnt_r      <= cnt_s;
            grant_r    <= grant_s;
            hex_r      <= hex_s;
            digit_en_r <= (state_s == SHOW) ? 8'hFF : 8'h00;
            active_r   <= (state_s == SHOW);
        end
    end

    assign grant    = grant_r;
    assign owner    = owner_r;
    assign HEX_out  = hex_r;
    assign digit_en = digit_en_r;
    assign active   = active_r;

endmodule

// File: tb/tb_display_share_scheduler.sv
// Scoreboard bench for display_share_scheduler: a reference model predicts each cycle's
// outputs into a queue and a monitor compares them on the falling clock edge.
module tb_display_share_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic          clock;
    logic          reset;
    logic [N-1:0]  req;
    logic [31:0]   vals [N];
    logic [32*N-1:0] value;
    logic          hold;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic [31:0]   HEX_out;
    logic [7:0]    digit_en;
    logic          active;

    assign value = {vals[3], vals[2], vals[1], vals[0]};

    display_share_scheduler #(.N_REQ(N), .DWELL_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .req(req), .value(value), .hold(hold),
        .grant(grant), .owner(owner), .HEX_out(HEX_out), .digit_en(digit_en), .active(active)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [31:0] hex;
        logic [7:0]  de;
        logic        act;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    // Model: current owner (-1 = nobody), dwell position, next search start.
    int   m_owner;
    int   m_cnt;
    int   m_ptr;

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_from(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++) begin
            if (r[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        if (m_owner < 0) begin
            e.grant = 4'b0000; e.owner = 2'd0; e.hex = 32'h0; e.de = 8'h00; e.act = 1'b0;
        end else begin
            e.grant = 4'(1 << m_owner);
            e.owner = 2'(m_owner);
`ifdef OWNER_TAG_EN
            e.hex   = {4'(m_owner), vals[m_owner][27:0]};
`else
            e.hex   = vals[m_owner];
`endif
            e.de    = 8'hFF;
            e.act   = 1'b1;
        end
        return e;
    endfunction

    // Reference model: one ownership decision per rising edge.
    initial begin
        int w;
        m_owner = -1; m_cnt = 0; m_ptr = 0;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_owner = -1; m_cnt = 0; m_ptr = 0;
                sb.delete();
                sb.push_back(expect_now());
            end else begin
                if (m_owner < 0) begin
                    w = find_from(req, m_ptr);
                    if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; end
                    m_cnt = 0;
                end else if (!req[m_owner] || (m_cnt == D - 1 && !hold)) begin
                    w = find_from(req, (m_owner + 1) % N);
                    m_owner = w;
                    if (w >= 0) m_ptr = (w + 1) % N;
                    m_cnt = 0;
                end else if (!hold) begin
                    m_cnt++;
                end
                sb.push_back(expect_now());
            end
        end
    end

    // Monitor: registered outputs are settled by the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_grant", 32'(grant), 32'(e.grant));
                chk("sb_owner", 32'(owner), 32'(e.owner));
                chk("sb_hex", HEX_out, e.hex);
                chk("sb_digit_en", 32'(digit_en), 32'(e.de));
                chk("sb_active", 32'(active), 32'(e.act));
            end
        end
    end

    initial begin
        reset = 1'b0; hold = 1'b0; req = 4'b0101;
        vals[0] = 32'h69; vals[1] = 32'h0; vals[2] = 32'hCAFE; vals[3] = 32'h0;

        // 1: reset, then rotate 0 -> 2 -> 0
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_hex", HEX_out, 32'h0);
        chk("rst_de", 32'(digit_en), 32'h0);
        #3 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t1_grant0", 32'(grant), 32'h1);
        chk("t1_hex0", HEX_out, 32'h69);
        chk("t1_de", 32'(digit_en), 32'hFF);
        repeat (4) @(negedge clock);
        chk("t1_grant2", 32'(grant), 32'h4);
`ifdef OWNER_TAG_EN
        chk("t1_hex2", HEX_out, 32'h2000CAFE);
`else
        chk("t1_hex2", HEX_out, 32'hCAFE);
`endif
        repeat (4) @(negedge clock);
        chk("t1_grant0b", 32'(grant), 32'h1);

        // 2: single requester keeps the display, live value tracking
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            vals[1] = $urandom;
        end
        @(negedge clock);
        chk("t2_grant1", 32'(grant), 32'h2);

        // 3: owner drop mid-dwell, then drop all
        req = 4'b0001;
        @(negedge clock);
        @(negedge clock);
        req = 4'b1000;
        @(negedge clock);
        chk("t3_grant3", 32'(grant), 32'h8);
        req = 4'b0000;
        @(negedge clock);
        chk("t3_idle_grant", 32'(grant), 32'h0);
        chk("t3_idle_hex", HEX_out, 32'h0);
        chk("t3_idle_de", 32'(digit_en), 32'h0);
        chk("t3_idle_act", 32'(active), 32'h0);

        // 4: hold at the last dwell cycle freezes rotation
        req = 4'b0011;
        repeat (4) @(negedge clock);
        hold = 1'b1;
        repeat (10) @(negedge clock);
        chk("t4_hold_grant", 32'(grant), 32'h1);
        hold = 1'b0;
        @(negedge clock);
        chk("t4_release_grant", 32'(grant), 32'h2);

        // 5: asynchronous reset mid-dwell, then arbitration from index 0
        @(posedge clock);
        #5 reset = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_act", 32'(active), 32'h0);
        chk("t5_async_hex", HEX_out, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        req = 4'b1110;
        @(negedge clock);
        chk("t5_restart_grant", 32'(grant), 32'h2);

        // Randomized traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) vals[$urandom_range(0, 3)] = $urandom;
        end
        hold = 1'b0;

`ifdef OWNER_TAG_EN
        // 6: owner tag replaces the top digit
        req = 4'b0100;
        vals[2] = 32'h12345678;
        repeat (3) @(negedge clock);
        chk("t6_tag_hex", HEX_out, 32'h22345678);
`endif

        repeat (2) @(negedge clock);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
